td4n: RTL and testbench

TD4N -- requirements
Module: td4n

---
 rtl/td4n.sv | 136 +++++++++++++
 tb/tb_td4n.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/td4n.sv
// td4n -- minimal 4-bit-style accumulator core with two data registers.
//
// One instruction retires per enabled clock edge. The program ROM is
// external and asynchronous: the core presents the program counter on
// iaddr and expects the matching instruction on idata in the same cycle.
//
// Parameters
//   DW  data / register / immediate width (DW >= 4)
//   AW  program address width (AW <= DW)
//
// Ports
//   clk      single clock, all state changes on its rising edge
//   rst      synchronous active-high reset
//   en       execute enable; an instruction retires only when en=1
//   iaddr    program counter, drives the external ROM address
//   idata    instruction word {op[3:0], im[DW-1:0]}
//   inp      input port, sampled by IN A / IN B
//   outp     registered output port, written by OUT B / OUT im
//   out_stb  one-cycle strobe following an edge that wrote outp
//   halted   high while the core is stopped by HLT
//   carry    registered carry flag
module td4n #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] iaddr,
  input  logic [DW+3:0] idata,
  input  logic [DW-1:0] inp,
  output logic [DW-1:0] outp,
  output logic          out_stb,
  output logic          halted,
  output logic          carry
);

  // Opcode map. Anything not listed here (1000, 1010, 1101) is a NOP.
  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_HLT   = 4'b1100;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [AW-1:0] pc;

  logic [3:0]    op;
  logic [DW-1:0] im;
  logic [DW:0]   sum_a;
  logic [DW:0]   sum_b;

  // Unsigned add returning {carry_out, sum} so the wrap and the carry come
  // from the same expression.
  function automatic logic [DW:0] add_c(input logic [DW-1:0] x,
                                        input logic [DW-1:0] y);
    add_c = {1'b0, x} + {1'b0, y};
  endfunction

  // Sequential successor of the PC; wraps from 2^AW-1 to 0 naturally.
  function automatic logic [AW-1:0] pc_next(input logic [AW-1:0] p);
    pc_next = p + AW'(1);
  endfunction

  assign op    = idata[DW+3:DW];
  assign im    = idata[DW-1:0];
  assign sum_a = add_c(a, im);
  assign sum_b = add_c(b, im);
  assign iaddr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      pc      <= '0;
      carry   <= 1'b0;
      outp    <= '0;
      out_stb <= 1'b0;
      halted  <= 1'b0;
    end else begin
      // The strobe is high only for the cycle after an OUT retires.
      out_stb <= 1'b0;
      if (en && !halted) begin
        // Defaults for a retiring instruction: advance and clear carry.
        // ADD overrides carry, jumps and HLT override the PC.
        carry <= 1'b0;
        pc    <= pc_next(pc);
        case (op)
          OP_ADD_A: begin
            a     <= sum_a[DW-1:0];
            carry <= sum_a[DW];
          end
          OP_ADD_B: begin
            b     <= sum_b[DW-1:0];
            carry <= sum_b[DW];
          end
          OP_MOV_A:  a <= im;
          OP_MOV_B:  b <= im;
          OP_MOV_AB: a <= b;
          OP_MOV_BA: b <= a;
          OP_IN_A:   a <= inp;
          OP_IN_B:   b <= inp;
          OP_OUT_B: begin
            outp    <= b;
            out_stb <= 1'b1;
          end
          OP_OUT_I: begin
            outp    <= im;
            out_stb <= 1'b1;
          end
          OP_JMP: pc <= im[AW-1:0];
          // The condition uses the carry left by the previous instruction;
          // the nonblocking clear above does not affect this read.
          OP_JNC: if (!carry) pc <= im[AW-1:0];
          // HLT parks the PC on its own address so a later reset is the
          // only way out.
          OP_HLT: begin
            pc     <= pc;
            halted <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_td4n.sv
// Bench for td4n: two instances (DW=4/AW=4 and DW=8/AW=6), each fed by a
// bench-owned ROM array. Expected post-edge state is queued before each edge
// and drained against the DUT one time unit after it.
module tb_td4n;

  localparam logic [2:0] F_A = 3'd0;
  localparam logic [2:0] F_B = 3'd1;
  localparam logic [2:0] F_PC = 3'd2;
  localparam logic [2:0] F_C = 3'd3;
  localparam logic [2:0] F_O = 3'd4;
  localparam logic [2:0] F_S = 3'd5;
  localparam logic [2:0] F_H = 3'd6;

  typedef struct packed {
    logic       sel;
    logic [2:0] f;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, en4, stb4, halted4, carry4;
  logic [3:0] iaddr4, inp4, outp4;
  logic [7:0] idata4;
  logic [7:0] rom4 [16];

  logic       rst8, en8, stb8, halted8, carry8;
  logic [5:0] iaddr8;
  logic [7:0] inp8, outp8;
  logic [11:0] idata8;
  logic [11:0] rom8 [64];

  assign idata4 = rom4[iaddr4];
  assign idata8 = rom8[iaddr8];

  td4n #(.DW(4), .AW(4)) u4 (
    .clk(clk), .rst(rst4), .en(en4), .iaddr(iaddr4), .idata(idata4),
    .inp(inp4), .outp(outp4), .out_stb(stb4), .halted(halted4), .carry(carry4)
  );

  td4n #(.DW(8), .AW(6)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .iaddr(iaddr8), .idata(idata8),
    .inp(inp8), .outp(outp8), .out_stb(stb8), .halted(halted8), .carry(carry8)
  );

  exp_t exp_q[$];
  int n_asserts = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_asserts++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic string fname(input logic [2:0] f);
    case (f)
      F_A:     return "a";
      F_B:     return "b";
      F_PC:    return "pc";
      F_C:     return "carry";
      F_O:     return "outp";
      F_S:     return "out_stb";
      default: return "halted";
    endcase
  endfunction

  function automatic logic [7:0] obs(input logic sel, input logic [2:0] f);
    if (sel) begin
      case (f)
        F_A:     return u8.a;
        F_B:     return u8.b;
        F_PC:    return {2'b00, iaddr8};
        F_C:     return {7'd0, carry8};
        F_O:     return outp8;
        F_S:     return {7'd0, stb8};
        default: return {7'd0, halted8};
      endcase
    end else begin
      case (f)
        F_A:     return {4'd0, u4.a};
        F_B:     return {4'd0, u4.b};
        F_PC:    return {4'd0, iaddr4};
        F_C:     return {7'd0, carry4};
        F_O:     return {4'd0, outp4};
        F_S:     return {7'd0, stb4};
        default: return {7'd0, halted4};
      endcase
    end
  endfunction

  task automatic push(input logic sel, input logic [2:0] f, input logic [7:0] v);
    exp_t e;
    e.sel = sel;
    e.f   = f;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic push_state(input logic sel, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] pc, input logic c, input logic [7:0] o,
                            input logic s, input logic h);
    push(sel, F_A, a);
    push(sel, F_B, b);
    push(sel, F_PC, pc);
    push(sel, F_C, {7'd0, c});
    push(sel, F_O, o);
    push(sel, F_S, {7'd0, s});
    push(sel, F_H, {7'd0, h});
  endtask

  task automatic edge_chk(input string phase);
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s.%s%0d", phase, fname(e.f), e.sel ? 8 : 4),
               obs(e.sel, e.f), e.v);
    end
  endtask

  task automatic fill4(input logic [7:0] w);
    for (int i = 0; i < 16; i++) rom4[i] = w;
  endtask

  task automatic reset4(input string phase);
    rst4 = 1'b1;
    en4  = 1'b1;
    push_state(1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    edge_chk(phase);
    rst4 = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; en4 = 1'b0; inp4 = 4'h0;
    rst8 = 1'b1; en8 = 1'b0; inp8 = 8'h00;
    fill4(8'h80);
    for (int i = 0; i < 64; i++) rom8[i] = 12'h800;
    #2;

    // Reset state of both instances.
    push_state(1'b1, 8'h0, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    reset4("rst");

    // MOV A,3 / ADD A,14 / JNC 0 (not taken) / JNC 5 (taken), with an
    // en-low gap while carry is set.
    rom4[0] = 8'h33; rom4[1] = 8'h0E; rom4[2] = 8'hE0; rom4[3] = 8'hE5;
    en4 = 1'b1;
    push_state(1'b0, 8'h3, 8'h0, 8'h1, 1'b0, 8'h0, 1'b0, 1'b0);
    edge_chk("jnc");
    push_state(1'b0, 8'h1, 8'h0, 8'h2, 1'b1, 8'h0, 1'b0, 1'b0);
    edge_chk("jnc");
    en4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inp4 = (i % 2 == 0) ? 4'hF : 4'h5;
      push_state(1'b0, 8'h1, 8'h0, 8'h2, 1'b1, 8'h0, 1'b0, 1'b0);
      edge_chk("enlow");
    end
    en4 = 1'b1;
    push_state(1'b0, 8'h1, 8'h0, 8'h3, 1'b0, 8'h0, 1'b0, 1'b0);
    edge_chk("jnc_nt");
    push_state(1'b0, 8'h1, 8'h0, 8'h5, 1'b0, 8'h0, 1'b0, 1'b0);
    edge_chk("jnc_t");

    // MOV B,5 / OUT B / OUT 10, then an en-low edge and a NOP.
    fill4(8'h80);
    rom4[0] = 8'h75; rom4[1] = 8'h90; rom4[2] = 8'hBA;
    reset4("rst_out");
    push_state(1'b0, 8'h0, 8'h5, 8'h1, 1'b0, 8'h0, 1'b0, 1'b0);
    edge_chk("out");
    push_state(1'b0, 8'h0, 8'h5, 8'h2, 1'b0, 8'h5, 1'b1, 1'b0);
    edge_chk("out");
    push_state(1'b0, 8'h0, 8'h5, 8'h3, 1'b0, 8'hA, 1'b1, 1'b0);
    edge_chk("out");
    en4 = 1'b0;
    push_state(1'b0, 8'h0, 8'h5, 8'h3, 1'b0, 8'hA, 1'b0, 1'b0);
    edge_chk("out_en0");
    en4 = 1'b1;
    push_state(1'b0, 8'h0, 8'h5, 8'h4, 1'b0, 8'hA, 1'b0, 1'b0);
    edge_chk("out_nop");

    // Register moves, IN, ADD B, odd NOPs, JMP.
    fill4(8'h80);
    rom4[0] = 8'h79; rom4[1] = 8'h10; rom4[2] = 8'h72; rom4[3] = 8'h5F;
    rom4[4] = 8'hD0; rom4[5] = 8'h08; rom4[6] = 8'h40; rom4[7] = 8'h20;
    rom4[8] = 8'h60; rom4[9] = 8'h0F; rom4[10] = 8'hA0; rom4[11] = 8'hF2;
    reset4("rst_mix");
    inp4 = 4'h3;
    push_state(1'b0, 8'h0, 8'h9, 8'd1, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("mov_b");
    push_state(1'b0, 8'h9, 8'h9, 8'd2, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("mov_ab");
    push_state(1'b0, 8'h9, 8'h2, 8'd3, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("mov_b2");
    push_state(1'b0, 8'h9, 8'h1, 8'd4, 1'b1, 8'h0, 1'b0, 1'b0); edge_chk("add_b");
    push_state(1'b0, 8'h9, 8'h1, 8'd5, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("nop_d");
    push_state(1'b0, 8'h1, 8'h1, 8'd6, 1'b1, 8'h0, 1'b0, 1'b0); edge_chk("add_a");
    inp4 = 4'h6;
    push_state(1'b0, 8'h1, 8'h1, 8'd7, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("mov_ba");
    push_state(1'b0, 8'h6, 8'h1, 8'd8, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("in_a");
    inp4 = 4'hC;
    push_state(1'b0, 8'h6, 8'hC, 8'd9, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("in_b");
    push_state(1'b0, 8'h5, 8'hC, 8'd10, 1'b1, 8'h0, 1'b0, 1'b0); edge_chk("add_a2");
    push_state(1'b0, 8'h5, 8'hC, 8'd11, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("nop_a");
    push_state(1'b0, 8'h5, 8'hC, 8'd2, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("jmp");

    // All-NOP ROM: PC wraps 15 -> 0.
    fill4(8'h80);
    reset4("rst_nop");
    for (int k = 1; k <= 17; k++) begin
      push(1'b0, F_PC, 8'(k % 16));
      push(1'b0, F_C, 8'h0);
      edge_chk("wrap");
    end

    // HLT at address 2 after an ADD that sets carry.
    fill4(8'h80);
    rom4[0] = 8'h3F; rom4[1] = 8'h01; rom4[2] = 8'hC0;
    reset4("rst_hlt");
    push_state(1'b0, 8'hF, 8'h0, 8'd1, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("hlt_pre");
    push_state(1'b0, 8'h0, 8'h0, 8'd2, 1'b1, 8'h0, 1'b0, 1'b0); edge_chk("hlt_add");
    push_state(1'b0, 8'h0, 8'h0, 8'd2, 1'b0, 8'h0, 1'b0, 1'b1); edge_chk("hlt");
    for (int i = 0; i < 10; i++) begin
      inp4 = 4'(i);
      push_state(1'b0, 8'h0, 8'h0, 8'd2, 1'b0, 8'h0, 1'b0, 1'b1);
      edge_chk("halted");
    end
    reset4("hlt_rst");
    push_state(1'b0, 8'hF, 8'h0, 8'd1, 1'b0, 8'h0, 1'b0, 1'b0);
    edge_chk("hlt_resume");

    // Wide instance: ADD overflow, JMP with oversized immediate, IN A.
    rst4 = 1'b1;
    rom8[0] = 12'h301; rom8[1] = 12'h0FF; rom8[2] = 12'hFFF; rom8[63] = 12'h200;
    rst8 = 1'b0; en8 = 1'b1; inp8 = 8'h5A;
    push_state(1'b1, 8'h01, 8'h0, 8'd1, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("w_mov");
    push_state(1'b1, 8'h00, 8'h0, 8'd2, 1'b1, 8'h0, 1'b0, 1'b0); edge_chk("w_add");
    push_state(1'b1, 8'h00, 8'h0, 8'd63, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("w_jmp");
    inp8 = 8'hA5;
    push_state(1'b1, 8'hA5, 8'h0, 8'd0, 1'b0, 8'h0, 1'b0, 1'b0); edge_chk("w_in");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
